result_writer_8lane: RTL and testbench

RESULT_WRITER_8LANE -- requirements
Module: result_writer_8lane

---
 rtl/mm_store_pkg.sv | 17 +
 rtl/wr_hold_reg.sv | 37 +++
 rtl/result_writer_8lane.sv | 98 +++++++++
 tb/tb_result_writer_8lane.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_store_pkg.sv
// Shared definitions for the matrix result store path: FSM states and
// geometry of one stored result (lanes per beat, address width, beat count).
package mm_store_pkg;

  localparam int LANES       = 8;
  localparam int ADDR_W      = 14;
  localparam int TOTAL_WORDS = 4096;
  localparam int BEATS       = TOTAL_WORDS / LANES;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/wr_hold_reg.sv
// Single-entry output register between the beat producer and the result
// memory. A new beat may be loaded whenever the register is empty or is
// being drained in the same cycle; otherwise contents hold unchanged.
module wr_hold_reg #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  input  logic [ADDR_W-1:0] src_addr,
  output logic              src_ready,
  output logic              dst_valid,
  output logic [DATA_W-1:0] dst_data,
  output logic [ADDR_W-1:0] dst_addr,
  input  logic              dst_ready
);

  assign src_ready = !dst_valid || dst_ready;

  // Load on accept, drop valid after a handshake with no new beat behind it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dst_valid <= 1'b0;
      dst_data  <= '0;
      dst_addr  <= '0;
    end else if (src_valid && src_ready) begin
      dst_valid <= 1'b1;
      dst_data  <= src_data;
      dst_addr  <= src_addr;
    end else if (dst_ready) begin
      dst_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/result_writer_8lane.sv
// Streams one matrix result (TOTAL_WORDS words, LANES words per beat) into
// the result memory. Each store starts with a start pulse, writes beats at
// ascending word addresses from 0, and ends with a sticky done flag once the
// final beat has been handshaken by the memory.
module result_writer_8lane
  import mm_store_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int LANES       = 8,
  parameter int TOTAL_WORDS = 4096
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    in_ready,
  input  logic                    mem_ready,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_base,
  output logic [LANES*DATA_W-1:0] wr_data,
  output logic [9:0]              beat_count,
  output logic                    busy,
  output logic                    done
);

  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(LANES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL_WORDS - LANES);
  localparam logic [9:0]        LAST_BEAT = 10'(TOTAL_WORDS / LANES - 1);

  state_t            state;
  logic [ADDR_W-1:0] acc_addr;
  logic              run;
  logic              hold_ready;
  logic              accept;
  logic              wr_hs;
  logic              start_ok;
  logic              last_accept;
  logic              last_hs;

  assign run         = (state == ST_RUN);
  assign in_ready    = run && hold_ready;
  assign accept      = in_valid && in_ready;
  assign wr_hs       = wr_en && mem_ready;
  assign start_ok    = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_accept = accept && (acc_addr == LAST_ADDR);
  assign last_hs     = wr_hs && (beat_count == LAST_BEAT);
  assign busy        = (state == ST_RUN) || (state == ST_DRAIN);

  // Store sequencing: accept all beats, drain the last write, then park in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start)       state <= ST_RUN;
        ST_RUN:   if (last_accept) state <= ST_DRAIN;
        ST_DRAIN: if (last_hs)     state <= ST_DONE;
        ST_DONE:  if (start)       state <= ST_RUN;
        default:                   state <= ST_IDLE;
      endcase
    end
  end

  // Acceptance address, completed-write count and sticky done; a start clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_addr   <= '0;
      beat_count <= '0;
      done       <= 1'b0;
    end else if (start_ok) begin
      acc_addr   <= '0;
      beat_count <= '0;
      done       <= 1'b0;
    end else begin
      if (accept) acc_addr <= acc_addr + STEP;
      if (wr_hs) beat_count <= beat_count + 10'd1;
      if ((state == ST_DRAIN) && last_hs) done <= 1'b1;
    end
  end

  wr_hold_reg #(
    .DATA_W (LANES*DATA_W),
    .ADDR_W (ADDR_W)
  ) u_hold (
    .clk       (clk),
    .reset     (reset),
    .src_valid (in_valid && run),
    .src_data  (in_data),
    .src_addr  (acc_addr),
    .src_ready (hold_ready),
    .dst_valid (wr_en),
    .dst_data  (wr_data),
    .dst_addr  (wr_base),
    .dst_ready (mem_ready)
  );

endmodule

// File: tb/tb_result_writer_8lane.sv
// Bench for result_writer_8lane: a cycle table for the start of a store,
// hand sequences for stalls, ignored starts and mid-store reset, and a
// randomized store checked by a beat-order scoreboard and a memory image.
module tb_result_writer_8lane;

  localparam int DW    = 16;
  localparam int NL    = 8;
  localparam int VW    = DW * NL;
  localparam int BEATS = 512;
  localparam int WORDS = 4096;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [VW-1:0] in_data;
  logic          in_ready;
  logic          mem_ready;
  logic          wr_en;
  logic [13:0]   wr_base;
  logic [VW-1:0] wr_data;
  logic [9:0]    beat_count;
  logic          busy;
  logic          done;

  result_writer_8lane #(.DATA_W(DW), .LANES(NL), .TOTAL_WORDS(WORDS)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_ready  (mem_ready),
    .wr_en      (wr_en),
    .wr_base    (wr_base),
    .wr_data    (wr_data),
    .beat_count (beat_count),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passed = 0;
  int          acc_cnt;
  int          hs_cnt;
  logic [15:0] salt;
  logic [15:0] mem [0:WORDS-1];

  logic          s_rdy, s_wr, s_busy, s_done;
  logic [13:0]   s_base;
  logic [9:0]    s_bc;
  logic [VW-1:0] s_data;

  typedef struct {
    logic       st, iv, mr;
    logic       e_rdy, e_wr, e_busy, e_done;
    logic [9:0] e_bc;
    logic [13:0] e_base;
  } vec_t;
  vec_t tbl [12];

  // Beat n carries word n*8+k on lane k, optionally scrambled by a salt.
  function automatic logic [VW-1:0] beat_word(input int n, input logic [15:0] sl);
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < NL; k++) v[k*DW +: DW] = 16'(n*8 + k) ^ sl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clear_mem();
    for (int a = 0; a < WORDS; a++) mem[a] = 16'hFFFF;
  endtask

  task automatic check_mem(input string name);
    int errs;
    errs = 0;
    for (int a = 0; a < WORDS; a++)
      if (mem[a] !== (16'(a) ^ salt)) errs++;
    chk(name, VW'(errs), VW'(0));
  endtask

  // One clock: drive inputs, observe at the falling edge, then advance.
  task automatic cycle(input logic st, input logic iv, input logic mr);
    start     = st;
    in_valid  = iv;
    mem_ready = mr;
    in_data   = beat_word(acc_cnt, salt);
    @(negedge clk);
    s_rdy  = in_ready;
    s_wr   = wr_en;
    s_busy = busy;
    s_done = done;
    s_base = wr_base;
    s_bc   = beat_count;
    s_data = wr_data;
    if (in_valid && in_ready) begin
      if (acc_cnt >= BEATS) chk("over_accept", VW'(acc_cnt), VW'(BEATS - 1));
      acc_cnt++;
    end
    if (wr_en && mem_ready) begin
      if (hs_cnt >= BEATS) begin
        chk("extra_write", VW'(hs_cnt), VW'(BEATS - 1));
      end else begin
        chk("hs_base", VW'(wr_base), VW'(hs_cnt * 8));
        chk("hs_data", wr_data, beat_word(hs_cnt, salt));
        for (int k = 0; k < NL; k++) mem[int'(wr_base) + k] = wr_data[k*DW +: DW];
      end
      hs_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic new_store(input logic [15:0] sl);
    acc_cnt = 0;
    hs_cnt  = 0;
    salt    = sl;
    clear_mem();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int guard, wr_cyc, gaps, last_wr, done_at, i;
    logic [13:0] last_base;

    tbl[0]  = '{1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0, 10'd0, 14'd0};
    tbl[1]  = '{1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0, 10'd0, 14'd0};
    tbl[2]  = '{1'b0,1'b1,1'b1, 1'b1,1'b0,1'b1,1'b0, 10'd0, 14'd0};
    tbl[3]  = '{1'b0,1'b1,1'b0, 1'b0,1'b1,1'b1,1'b0, 10'd0, 14'd0};
    tbl[4]  = '{1'b0,1'b1,1'b0, 1'b0,1'b1,1'b1,1'b0, 10'd0, 14'd0};
    tbl[5]  = '{1'b0,1'b0,1'b1, 1'b1,1'b1,1'b1,1'b0, 10'd0, 14'd0};
    tbl[6]  = '{1'b0,1'b1,1'b1, 1'b1,1'b0,1'b1,1'b0, 10'd1, 14'd0};
    tbl[7]  = '{1'b0,1'b1,1'b1, 1'b1,1'b1,1'b1,1'b0, 10'd1, 14'd8};
    tbl[8]  = '{1'b0,1'b0,1'b1, 1'b1,1'b1,1'b1,1'b0, 10'd2, 14'd16};
    tbl[9]  = '{1'b1,1'b0,1'b1, 1'b1,1'b0,1'b1,1'b0, 10'd3, 14'd16};
    tbl[10] = '{1'b0,1'b1,1'b1, 1'b1,1'b0,1'b1,1'b0, 10'd3, 14'd16};
    tbl[11] = '{1'b0,1'b0,1'b1, 1'b1,1'b1,1'b1,1'b0, 10'd3, 14'd24};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b0; in_data = '0;
    new_store(16'h0000);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", VW'(in_ready), VW'(0));
    chk("rst_wr_en", VW'(wr_en), VW'(0));
    chk("rst_wr_base", VW'(wr_base), VW'(0));
    chk("rst_wr_data", wr_data, VW'(0));
    chk("rst_beat_count", VW'(beat_count), VW'(0));
    chk("rst_busy", VW'(busy), VW'(0));
    chk("rst_done", VW'(done), VW'(0));
    reset = 1'b0;

    // Store 1: cycle table over the first beats, then stream to completion.
    for (int r = 0; r < 12; r++) begin
      cycle(tbl[r].st, tbl[r].iv, tbl[r].mr);
      chk($sformatf("vec%0d_in_ready", r), VW'(s_rdy), VW'(tbl[r].e_rdy));
      chk($sformatf("vec%0d_wr_en", r), VW'(s_wr), VW'(tbl[r].e_wr));
      chk($sformatf("vec%0d_busy", r), VW'(s_busy), VW'(tbl[r].e_busy));
      chk($sformatf("vec%0d_done", r), VW'(s_done), VW'(tbl[r].e_done));
      chk($sformatf("vec%0d_beat_count", r), VW'(s_bc), VW'(tbl[r].e_bc));
      chk($sformatf("vec%0d_wr_base", r), VW'(s_base), VW'(tbl[r].e_base));
    end
    guard = 0;
    while (!s_done && guard < 3000) begin cycle(1'b0, 1'b1, 1'b1); guard++; end
    chk("s1_done", VW'(s_done), VW'(1));
    chk("s1_beat_count", VW'(s_bc), VW'(BEATS));
    chk("s1_handshakes", VW'(hs_cnt), VW'(BEATS));
    check_mem("s1_mem");
    for (int j = 0; j < 2; j++) begin
      cycle(1'b0, 1'b1, 1'b1);
      chk("done_in_ready", VW'(s_rdy), VW'(0));
      chk("done_sticky", VW'(s_done), VW'(1));
      chk("done_busy", VW'(s_busy), VW'(0));
    end

    // Store 2: restart from DONE, full throughput, lane/address image.
    new_store(16'h0000);
    cycle(1'b1, 1'b0, 1'b1);
    chk("s2_done_before_start", VW'(s_done), VW'(1));
    cycle(1'b0, 1'b1, 1'b1);
    chk("s2_done_cleared", VW'(s_done), VW'(0));
    chk("s2_busy", VW'(s_busy), VW'(1));
    chk("s2_beat_count0", VW'(s_bc), VW'(0));
    chk("s2_in_ready", VW'(s_rdy), VW'(1));
    wr_cyc = 0; gaps = 0; last_wr = -1; done_at = -1; i = 0; last_base = '0;
    while (done_at < 0 && i < 2000) begin
      cycle(1'b0, 1'b1, 1'b1);
      if (s_wr) begin
        if (last_wr >= 0 && last_wr != i - 1) gaps++;
        last_wr = i;
        last_base = s_base;
        wr_cyc++;
      end
      if (s_done) done_at = i;
      i++;
    end
    chk("s2_write_cycles", VW'(wr_cyc), VW'(BEATS));
    chk("s2_write_gaps", VW'(gaps), VW'(0));
    chk("s2_done_timing", VW'(done_at), VW'(last_wr + 1));
    chk("s2_last_base", VW'(last_base), VW'(14'h0FF8));
    chk("s2_beat_count", VW'(s_bc), VW'(BEATS));
    check_mem("s2_mem");

    // Store 3: stall on beat 5, ignored start at beat 100, reset at beat 200.
    new_store(16'h1234);
    cycle(1'b1, 1'b0, 1'b1);
    guard = 0;
    while (acc_cnt < 6 && guard < 100) begin cycle(1'b0, 1'b1, 1'b1); guard++; end
    for (int j = 0; j < 3; j++) begin
      cycle(1'b0, 1'b1, 1'b0);
      chk("stall_wr_en", VW'(s_wr), VW'(1));
      chk("stall_wr_base", VW'(s_base), VW'(14'h0028));
      chk("stall_wr_data", s_data, beat_word(5, salt));
      chk("stall_in_ready", VW'(s_rdy), VW'(0));
    end
    cycle(1'b0, 1'b1, 1'b1);
    chk("release_wr_en", VW'(s_wr), VW'(1));
    chk("release_wr_base", VW'(s_base), VW'(14'h0028));
    chk("release_wr_data", s_data, beat_word(5, salt));
    chk("release_in_ready", VW'(s_rdy), VW'(1));
    guard = 0;
    while (acc_cnt < 100 && guard < 400) begin cycle(1'b0, 1'b1, 1'b1); guard++; end
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    chk("ign_start_base", VW'(s_base), VW'(14'h0320));
    chk("ign_start_busy", VW'(s_busy), VW'(1));
    chk("ign_start_wr_en", VW'(s_wr), VW'(1));
    guard = 0;
    while (acc_cnt < 201 && guard < 400) begin cycle(1'b0, 1'b1, 1'b1); guard++; end
    chk("pre_reset_wr_en", VW'(wr_en), VW'(1));
    chk("pre_reset_wr_base", VW'(wr_base), VW'(14'h0640));
    reset = 1'b1;
    #1;
    chk("mid_rst_wr_en", VW'(wr_en), VW'(0));
    chk("mid_rst_wr_base", VW'(wr_base), VW'(0));
    chk("mid_rst_wr_data", wr_data, VW'(0));
    chk("mid_rst_beat_count", VW'(beat_count), VW'(0));
    chk("mid_rst_busy", VW'(busy), VW'(0));
    chk("mid_rst_done", VW'(done), VW'(0));
    chk("mid_rst_in_ready", VW'(in_ready), VW'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    acc_cnt = 0;
    hs_cnt  = 0;
    for (int j = 0; j < 3; j++) begin
      cycle(1'b0, 1'b1, 1'b1);
      chk("post_rst_in_ready", VW'(s_rdy), VW'(0));
      chk("post_rst_wr_en", VW'(s_wr), VW'(0));
      chk("post_rst_busy", VW'(s_busy), VW'(0));
    end

    // Store 4: random producer and memory back-pressure.
    new_store(16'hA5C3);
    cycle(1'b1, 1'b0, 1'b1);
    guard = 0;
    while (!s_done && guard < 8000) begin
      cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      guard++;
    end
    chk("rnd_done", VW'(s_done), VW'(1));
    chk("rnd_handshakes", VW'(hs_cnt), VW'(BEATS));
    chk("rnd_accepts", VW'(acc_cnt), VW'(BEATS));
    chk("rnd_beat_count", VW'(s_bc), VW'(BEATS));
    check_mem("rnd_mem");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
